// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Purpose  : Round-robin arbiter/sequencer sharing one external combinational
//            ALU between two requesters. A winning request is latched into the
//            ALU drive registers (IDLE), the ALU result is captured one cycle
//            later (EXEC), and the response is held until consumed (RESP).
// Ports    : clk, rst_n (async, active-low)
//            req{0,1}_valid/ready/op/a/b        request channels
//            resp{0,1}_valid/ready/result/zero/err response channels
//            alu_operation/alu_a/alu_b -> ALU,  alu_result <- ALU
//            busy                               high while state != IDLE
// Options  : `define ALU_SHARE_OPCHK_EN to trap op code all-ones as illegal
//            (ALU not driven, response result=0, zero=1, err=1). Without it,
//            every op is forwarded and resp*_err is tied low.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    output logic             resp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic             resp1_err,
    output logic [OPW-1:0]   alu_operation,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_last_gnt;
    logic             r_owner;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_gnt_valid;
    logic             w_gnt;
    logic             w_accept;
    logic             w_resp_hs;
    logic [OPW-1:0]   w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // ------------------------------------------------------------------------
    // Grant: a lone requester wins; on a tie the one not served last wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt_valid = req0_valid | req1_valid;
        w_gnt       = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt = ~r_last_gnt;
        end else if (req1_valid) begin
            w_gnt = 1'b1;
        end
    end

    assign w_accept = (r_state == c_ST_IDLE) && w_gnt_valid;
    assign w_sel_op = w_gnt ? req1_op : req0_op;
    assign w_sel_a  = w_gnt ? req1_a  : req0_a;
    assign w_sel_b  = w_gnt ? req1_b  : req0_b;

    // Only the owner's ready can complete the response; the other is ignored.
    assign w_resp_hs = (r_state == c_ST_RESP) &&
                       (r_owner ? resp1_ready : resp0_ready);

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)  w_next_state = c_ST_EXEC;
            c_ST_EXEC:                w_next_state = c_ST_RESP;
            c_ST_RESP: if (w_resp_hs) w_next_state = c_ST_IDLE;
            default:                  w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
`ifdef ALU_SHARE_OPCHK_EN
    localparam logic [OPW-1:0] c_OP_ILLEGAL = '1;

    logic r_illegal;
    logic r_err;
    logic w_is_illegal;

    assign w_is_illegal = (w_sel_op == c_OP_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
            r_owner    <= 1'b0;
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_illegal  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner    <= w_gnt;
                r_last_gnt <= w_gnt;
                r_illegal  <= w_is_illegal;
                // An illegal op leaves the ALU inputs at the previous op.
                if (!w_is_illegal) begin
                    r_alu_op <= w_sel_op;
                    r_alu_a  <= w_sel_a;
                    r_alu_b  <= w_sel_b;
                end
            end
            if (r_state == c_ST_EXEC) begin
                if (r_illegal) begin
                    r_result <= '0;
                    r_zero   <= 1'b1;
                    r_err    <= 1'b1;
                end else begin
                    r_result <= alu_result;
                    r_zero   <= (alu_result == '0);
                    r_err    <= 1'b0;
                end
            end
            if (w_resp_hs) begin
                r_err <= 1'b0;
            end
        end
    end

    assign resp0_err = r_err;
    assign resp1_err = r_err;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
            r_owner    <= 1'b0;
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner    <= w_gnt;
                r_last_gnt <= w_gnt;
                r_alu_op   <= w_sel_op;
                r_alu_a    <= w_sel_a;
                r_alu_b    <= w_sel_b;
            end
            if (r_state == c_ST_EXEC) begin
                r_result <= alu_result;
                r_zero   <= (alu_result == '0);
            end
        end
    end

    assign resp0_err = 1'b0;
    assign resp1_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req0_ready    = w_accept && !w_gnt;
    assign req1_ready    = w_accept &&  w_gnt;
    assign resp0_valid   = (r_state == c_ST_RESP) && !r_owner;
    assign resp1_valid   = (r_state == c_ST_RESP) &&  r_owner;
    assign resp0_result  = r_result;
    assign resp1_result  = r_result;
    assign resp0_zero    = r_zero;
    assign resp1_zero    = r_zero;
    assign alu_operation = r_alu_op;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_ctrl
// Purpose  : Directed self-checking bench for alu_share_ctrl with a behavioural
//            ALU and an expected-response scoreboard.
// Options  : honours ALU_SHARE_OPCHK_EN for the illegal-op step.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [15:0] resp0_result, resp1_result;
    logic        resp0_zero, resp1_zero, resp0_err, resp1_err;
    logic [2:0]  alu_operation;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        zero;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural ALU; unused code 111 returns a marker value.
    always_comb begin
        case (alu_operation)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = alu_a << alu_b[3:0];
            3'b110:  alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 16'hDEAD;
        endcase
    end

    alu_share_ctrl #(.WIDTH(16), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero), .resp1_err(resp1_err),
        .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] res, input logic z, input logic e);
        exp_t x;
        x.res = res; x.zero = z; x.err = e;
        sb.push_back(x);
    endtask

    // Present a request and hold it until accepted; returns just after the
    // accepting edge with valid dropped (DUT then in EXEC).
    task automatic issue(input bit port, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input logic z,
                         input logic e, input bit do_push);
        bit got = 0;
        if (port) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else      begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (port ? req1_ready : req0_ready) begin got = 1; break; end
            @(negedge clk);
        end
        check("accept_timeout", {31'd0, got}, 32'd1);
        if (got && do_push) push_exp(res, z, e);
        @(posedge clk);
        #1;
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Wait for a response on the port, compare to the scoreboard, handshake.
    // Returns on the negedge after the handshake edge.
    task automatic collect(input bit port);
        bit   seen = 0;
        exp_t x;
        for (int i = 0; i < 20; i++) begin
            if (port ? resp1_valid : resp0_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        check("resp_timeout", {31'd0, seen}, 32'd1);
        if (!seen) return;
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() == 0) return;
        x = sb.pop_front();
        check("other_valid", {31'd0, port ? resp0_valid : resp1_valid}, 32'd0);
        check("result", {16'd0, port ? resp1_result : resp0_result}, {16'd0, x.res});
        check("zero", {31'd0, port ? resp1_zero : resp0_zero}, {31'd0, x.zero});
        check("err", {31'd0, port ? resp1_err : resp0_err}, {31'd0, x.err});
        if (port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        check("idle_after_hs", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 0; resp1_ready = 0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_v0", {31'd0, resp0_valid}, 32'd0);
        check("rst_v1", {31'd0, resp1_valid}, 32'd0);
        check("rst_result", {16'd0, resp0_result}, 32'd0);
        check("rst_zero", {31'd0, resp0_zero}, 32'd0);
        check("rst_err", {31'd0, resp1_err}, 32'd0);
        check("rst_alu_op", {29'd0, alu_operation}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_alu_b", {16'd0, alu_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single add: ready same cycle, response two cycles later
        req0_op = 3'b000; req0_a = 16'h5555; req0_b = 16'h3333; req0_valid = 1'b1;
        #1;
        check("add_rdy0", {31'd0, req0_ready}, 32'd1);
        check("add_rdy1", {31'd0, req1_ready}, 32'd0);
        push_exp(16'h8888, 1'b0, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("add_exec_busy", {31'd0, busy}, 32'd1);
        check("add_exec_v0", {31'd0, resp0_valid}, 32'd0);
        check("add_exec_rdy", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        check("add_lat_v0", {31'd0, resp0_valid}, 32'd1);
        collect(0);

        // Round-robin tie from fresh round-robin state (last served was 0
        // above, so set last_gnt=1 via a reset to exercise the reset tie rule)
        rst_n = 1'b0; #1 rst_n = 1'b1;
        @(negedge clk);
        req0_op = 3'b001; req0_a = 16'h5555; req0_b = 16'hAAAA; req0_valid = 1'b1;
        req1_op = 3'b010; req1_a = 16'h9999; req1_b = 16'h3333; req1_valid = 1'b1;
        #1;
        check("tie_rdy0", {31'd0, req0_ready}, 32'd1);
        check("tie_rdy1", {31'd0, req1_ready}, 32'd0);
        push_exp(16'h0000, 1'b1, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        collect(0);
        #1;
        check("tie2_rdy1", {31'd0, req1_ready}, 32'd1);
        push_exp(16'h6666, 1'b0, 1'b0);
        @(posedge clk); #1 req1_valid = 1'b0;
        collect(1);
        // Next tie: last_gnt=1 so requester 0 wins
        req0_op = 3'b100; req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_valid = 1'b1;
        req1_op = 3'b000; req1_a = 16'h0001; req1_b = 16'h0002; req1_valid = 1'b1;
        #1;
        check("tie3_rdy0", {31'd0, req0_ready}, 32'd1);
        check("tie3_rdy1", {31'd0, req1_ready}, 32'd0);
        push_exp(16'h0FF0, 1'b0, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        collect(0);
        #1;
        check("tie4_rdy1", {31'd0, req1_ready}, 32'd1);
        push_exp(16'h0003, 1'b0, 1'b0);
        @(posedge clk); #1 req1_valid = 1'b0;
        collect(1);

        // Backpressure on requester 1 with requester 0 waiting
        issue(1, 3'b011, 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1);
        req0_op = 3'b000; req0_a = 16'h0010; req0_b = 16'h0020; req0_valid = 1'b1;
        @(negedge clk);
        check("bp_exec_rdy0", {31'd0, req0_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_v1", {31'd0, resp1_valid}, 32'd1);
            check("bp_result", {16'd0, resp1_result}, 32'h0000FFFF);
            check("bp_rdy0", {31'd0, req0_ready}, 32'd0);
        end
        collect(1);
        #1;
        check("bp_after_rdy0", {31'd0, req0_ready}, 32'd1);
        push_exp(16'h0030, 1'b0, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        collect(0);

        // Shift: ALU drive visible during EXEC
        issue(0, 3'b101, 16'h5555, 16'h0003, 16'hAAA8, 1'b0, 1'b0, 1);
        check("sll_alu_op", {29'd0, alu_operation}, 32'd5);
        check("sll_alu_a", {16'd0, alu_a}, 32'h00005555);
        check("sll_alu_b", {16'd0, alu_b}, 32'h00000003);
        collect(0);

        // Reset during EXEC of an xor: no response, outputs cleared at once
        issue(0, 3'b100, 16'h1234, 16'h00FF, 16'h0000, 1'b0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_v0", {31'd0, resp0_valid}, 32'd0);
        check("mid_rst_v1", {31'd0, resp1_valid}, 32'd0);
        check("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // last_gnt back to 1: requester 0 wins a tie even though it was last served
        req0_op = 3'b000; req0_a = 16'h0001; req0_b = 16'h0001; req0_valid = 1'b1;
        req1_op = 3'b000; req1_a = 16'h0002; req1_b = 16'h0002; req1_valid = 1'b1;
        #1;
        check("post_rst_rdy0", {31'd0, req0_ready}, 32'd1);
        push_exp(16'h0002, 1'b0, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        collect(0);
        #1;
        check("post_rst_rdy1", {31'd0, req1_ready}, 32'd1);
        push_exp(16'h0004, 1'b0, 1'b0);
        @(posedge clk); #1 req1_valid = 1'b0;
        collect(1);

        // Illegal op 111
`ifdef ALU_SHARE_OPCHK_EN
        issue(0, 3'b111, 16'hBEEF, 16'h1234, 16'h0000, 1'b1, 1'b1, 1);
        check("ill_alu_a", {16'd0, alu_a}, 32'h00000002);
        check("ill_alu_op", {29'd0, alu_operation}, 32'd0);
`else
        issue(0, 3'b111, 16'hBEEF, 16'h1234, 16'hDEAD, 1'b0, 1'b0, 1);
        check("ill_alu_op", {29'd0, alu_operation}, 32'd7);
        check("ill_alu_a", {16'd0, alu_a}, 32'h0000BEEF);
`endif
        collect(0);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
